// File: rtl/bp_pc_ctrl.sv
// rtl/bp_pc_ctrl.sv - fetch-stage PC controller driven by a 2-bit branch prediction
//
// Purpose:
//   Steers the fetch PC along the predicted path for beq instructions. It carries
//   the not-taken-path (alternate) address through the D and E slots. On a
//   mispredict of the branch in E, it redirects to that alternate address and
//   flushes IF/ID and ID/EX. It also counts resolved branches and mispredicts.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   iInstruction   instruction fetched at oPC this cycle
//   ibp_predict    [0] predict taken for fetched beq, [1] mispredict of branch in E
//   iBranch_regE   E-stage instruction is a beq
//   iStall         decode hazard stall (hold PC and D slot, bubble into E)
//   oPC            current fetch address
//   oFlush_IFID    squash IF/ID this cycle
//   oFlush_IDEX    squash ID/EX this cycle
//   oBranch_cnt    resolved beq count
//   oMiss_cnt      accepted mispredict count
module bp_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      iInstruction,
  input  logic [1:0]       ibp_predict,
  input  logic             iBranch_regE,
  input  logic             iStall,
  output logic [31:0]      oPC,
  output logic             oFlush_IFID,
  output logic             oFlush_IDEX,
  output logic [CNT_W-1:0] oBranch_cnt,
  output logic [CNT_W-1:0] oMiss_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic             valid_d_q, valid_d_d;
  logic [31:0]      alt_d_q, alt_d_d;
  logic             valid_e_q, valid_e_d;
  logic [31:0]      alt_e_q, alt_e_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic        is_beq;
  logic        pred_taken;
  logic        mispredict;
  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] tgt_pc;
  logic [31:0] fetch_alt;

  // Only the opcode and the immediate field take part in address generation.
  logic unused_instr_bits;
  assign unused_instr_bits = ^iInstruction[25:16];

  always_comb begin
    is_beq     = (iInstruction[31:26] == 6'd4);
    pred_taken = is_beq & ibp_predict[0];
    // A mispredict flag with no valid branch in E has nothing to recover, so it is dropped.
    mispredict = ibp_predict[1] & valid_e_q;
    seq_pc     = pc_q + 32'd4;
    br_off     = {{14{iInstruction[15]}}, iInstruction[15:0], 2'b00};
    tgt_pc     = seq_pc + br_off;
    // The alternate address is whichever path the fetch did not follow.
    fetch_alt  = pred_taken ? seq_pc : tgt_pc;

    pc_d         = seq_pc;
    valid_d_d    = is_beq;
    alt_d_d      = fetch_alt;
    valid_e_d    = valid_d_q;
    alt_e_d      = alt_d_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (mispredict) begin
      // Redirect wins over stall and over any prediction made this cycle;
      // everything younger than the branch in E is on the wrong path.
      pc_d      = alt_e_q;
      valid_d_d = 1'b0;
      alt_d_d   = alt_d_q;
      valid_e_d = 1'b0;
      alt_e_d   = alt_e_q;
    end else if (iStall) begin
      pc_d      = pc_q;
      valid_d_d = valid_d_q;
      alt_d_d   = alt_d_q;
      valid_e_d = 1'b0;
      alt_e_d   = alt_e_q;
    end else if (pred_taken) begin
      pc_d = tgt_pc;
    end

    if (iBranch_regE && valid_e_q) begin
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    end
    if (mispredict) begin
      miss_cnt_d = miss_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      valid_d_q    <= 1'b0;
      alt_d_q      <= 32'd0;
      valid_e_q    <= 1'b0;
      alt_e_q      <= 32'd0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      valid_d_q    <= valid_d_d;
      alt_d_q      <= alt_d_d;
      valid_e_q    <= valid_e_d;
      alt_e_q      <= alt_e_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign oPC         = pc_q;
  assign oFlush_IFID = mispredict;
  assign oFlush_IDEX = mispredict;
  assign oBranch_cnt = branch_cnt_q;
  assign oMiss_cnt   = miss_cnt_q;

endmodule
